// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and width helpers for the uart tx scheduler
//
// Purpose: holds the scheduler state encoding, the header byte base and the
// clog2-derived width helpers used by uart_tx_scheduler and rr_pick.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  // Header byte is HEADER_BASE with the owner index OR-ed into the low bits.
  localparam logic [7:0] HEADER_BASE = 8'hA0;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-burst transfer counter, able to hold max_burst itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// rtl/uart_tx_scheduler_rr_pick.sv - combinational round-robin picker
//
// Purpose: finds the first asserted request searching upward from ptr with
// wrap-around.
// Ports:
//   req   in  N  request vector
//   ptr   in  W  search start index (must be < N)
//   idx   out W  index of the selected request (0 when none)
//   found out 1  at least one request asserted
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Rotating the doubled vector right by ptr puts req[ptr] at bit 0, so the
  // lowest set bit of rot is the winner in round-robin order.
  logic [N-1:0] rot;
  logic [W:0]   sum;

  assign rot = N'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one uart transmitter
//
// Purpose: grants the uart tx path to one requester at a time, optionally
// prefixes each burst with a header byte, passes bytes through with zero
// latency and forces release after MAX_BURST bytes.
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   req_valid/req_data/req_last/req_ready  per-requester byte streams
//   tx_data/tx_valid/tx_ready              uart transmit handshake
//   grant_id               current owner
//   busy                   high outside IDLE
//   burst_trunc            one-cycle pulse after a forced release
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int HEADER_EN  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          busy,
  output logic                          burst_trunc
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  trunc_q;

  logic [ID_W-1:0]       pick_idx;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  valid_sel;
  logic                  last_sel;
  logic [CNT_W-1:0]      count_inc;
  logic                  count_hit;
  logic                  xfer;
  logic                  release_now;
  logic [ID_W-1:0]       ptr_next;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner's stream, selected by compare rather than a variable index.
  always_comb begin
    data_sel  = '0;
    valid_sel = 1'b0;
    last_sel  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        data_sel  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        valid_sel = req_valid[i];
        last_sel  = req_last[i];
      end
    end
  end

  assign count_inc   = count_q + CNT_W'(1);
  assign count_hit   = (count_inc == CNT_W'(MAX_BURST));
  assign release_now = xfer && (last_sel || count_hit);
  assign ptr_next    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    xfer      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = (HEADER_EN != 0) ? ST_HEADER : ST_DATA;
        end
      end
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(HEADER_BASE) | DATA_WIDTH'(grant_q);
        if (tx_ready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_valid = valid_sel;
        tx_data  = data_sel;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == ID_W'(i)) begin
            req_ready[i] = tx_ready;
          end
        end
        xfer = valid_sel && tx_ready;
        if (release_now) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            count_q <= '0;
          end
        end
        ST_HEADER: begin
          if (tx_ready) begin
            count_q <= '0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            count_q <= count_inc;
          end
          if (release_now) begin
            rr_ptr_q <= ptr_next;
            // A final byte that also carries last is a normal end, not a cut.
            trunc_q  <= count_hit && !last_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign burst_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            burst_trunc;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .HEADER_EN  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_trunc (burst_trunc)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- requester / uart drivers ----------------
  logic [8:0]  rq [NR][$];      // {last, data} still to be offered
  logic [7:0]  sb [NR][$];      // bytes each requester must see delivered
  bit [NR-1:0] stall = '0;
  bit          rand_stall = 1'b0;
  int          rdy_mode = 0;    // 0: always ready, 1: 1-0-0-1 pattern, 2: random
  int          pat_idx = 0;
  bit [NR-1:0] drv_fire;
  logic [3:0]  pat = 4'b1001;

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    rq[r].push_back({last, d});
    sb[r].push_back(d);
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      drv_fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (drv_fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rand_stall) stall[i] = ($urandom_range(0, 3) == 0);
        if (rq[i].size() > 0 && !stall[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      case (rdy_mode)
        1: begin tx_ready = pat[pat_idx % 4]; pat_idx++; end
        2: tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // ---------------- behavioural model and per-cycle compare ----------------
  int         m_phase = 0;   // 0 idle, 1 header owed, 2 streaming data
  int         m_owner = 0;
  int         m_ptr = 0;
  int         m_nsent = 0;
  bit         m_trunc = 1'b0;
  bit         nt;
  bit         f;
  int         j;
  bit         e_tv;
  logic [7:0] e_td;
  logic [3:0] e_rdy;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_td;
  logic [7:0] txlog [$];
  logic [7:0] hdrlog [$];
  int         trunc_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_burst_trunc", burst_trunc, 0);
        m_phase = 0; m_owner = 0; m_ptr = 0; m_nsent = 0; m_trunc = 0;
        prev_hold = 0;
      end else begin
        e_tv  = (m_phase == 1) || (m_phase == 2 && req_valid[m_owner]);
        e_td  = (m_phase == 1) ? (8'hA0 | 8'(m_owner)) : req_data[m_owner*DW +: DW];
        e_rdy = (m_phase == 2 && tx_ready) ? 4'(1 << m_owner) : 4'h0;
        chk("busy", busy, m_phase != 0);
        chk("grant_id", grant_id, m_owner);
        chk("burst_trunc", burst_trunc, m_trunc);
        chk("tx_valid", tx_valid, e_tv);
        if (e_tv) chk("tx_data", tx_data, e_td);
        chk("req_ready", req_ready, e_rdy);
        if (prev_hold && tx_valid) chk("tx_data_hold", tx_data, prev_td);
        prev_hold = tx_valid && !tx_ready;
        prev_td   = tx_data;
        if (burst_trunc) trunc_cnt++;
        if (tx_valid && tx_ready) begin
          txlog.push_back(tx_data);
          if (m_phase == 1) hdrlog.push_back(tx_data);
        end
        nt = 1'b0;
        case (m_phase)
          0: begin
            f = 1'b0;
            for (int k = 0; k < NR; k++) begin
              j = (m_ptr + k) % NR;
              if (!f && req_valid[j]) begin
                f = 1'b1;
                m_owner = j;
                m_phase = 1;
              end
            end
          end
          1: if (tx_ready) begin m_phase = 2; m_nsent = 0; end
          default: begin
            if (req_valid[m_owner] && tx_ready) begin
              chk("sb_has_byte", sb[m_owner].size() > 0, 1);
              if (sb[m_owner].size() > 0) chk("sb_data", tx_data, sb[m_owner].pop_front());
              m_nsent++;
              if (req_last[m_owner] || m_nsent == MB) begin
                nt = (m_nsent == MB) && !req_last[m_owner];
                m_phase = 0;
                m_ptr = (m_owner + 1) % NR;
              end
            end
          end
        endcase
        m_trunc = nt;
      end
    end
  end

  // ---------------- scenario helpers ----------------
  logic [7:0] exp_q [$];

  task automatic ex(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic chk_seq(input string name, input logic [7:0] got [$]);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      sb[i].delete();
    end
    stall = '0;
    rand_stall = 1'b0;
    rdy_mode = 0;
  endtask

  task automatic clear_logs();
    txlog.delete();
    hdrlog.delete();
    trunc_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    clear_stim();
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_drain(input string name);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 2000) begin
      @(posedge clk); #2;
      n++;
      pend = busy;
      for (int i = 0; i < NR; i++) if (rq[i].size() > 0) pend = 1'b1;
    end
    chk({name, "_drain_timeout"}, pend, 0);
    repeat (2) begin @(posedge clk); #2; end
    for (int i = 0; i < NR; i++) chk($sformatf("%s_sb_left%0d", name, i), sb[i].size(), 0);
  endtask

  task automatic wait_log(input string name, input int cnt);
    int n;
    n = 0;
    while (txlog.size() < cnt && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_log_timeout"}, txlog.size() >= cnt, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b1;
    clear_stim();
    clear_logs();

    // single request with header
    do_reset();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b1);
    wait_drain("single");
    ex(8'hA2); ex(8'h11); ex(8'h22);
    chk_seq("single_tx", txlog);
    chk("single_idle", busy, 0);
    chk("single_model_ptr", m_ptr, 3);
    clear_logs();
    push_byte(0, 8'h33, 1'b1);
    push_byte(3, 8'h44, 1'b1);
    wait_drain("ptr3");
    ex(8'hA3); ex(8'hA0);
    chk_seq("ptr3_hdr", hdrlog);

    // round-robin with all requesters continuously valid
    do_reset();
    for (int r = 0; r < NR; r++) begin
      push_byte(r, 8'h50 + 8'(r), 1'b1);
      push_byte(r, 8'h60 + 8'(r), 1'b1);
    end
    wait_drain("rr");
    ex(8'hA0); ex(8'hA1); ex(8'hA2); ex(8'hA3);
    ex(8'hA0); ex(8'hA1); ex(8'hA2); ex(8'hA3);
    chk_seq("rr_hdr", hdrlog);

    // truncation after MAX_BURST bytes, then regrant for the rest
    do_reset();
    for (int k = 0; k < 6; k++) push_byte(1, 8'h70 + 8'(k), k == 5);
    wait_drain("trunc");
    ex(8'hA1); ex(8'h70); ex(8'h71); ex(8'h72); ex(8'h73);
    ex(8'hA1); ex(8'h74); ex(8'h75);
    chk_seq("trunc_tx", txlog);
    chk("trunc_pulses", trunc_cnt, 1);

    // last on exactly the MAX_BURST-th byte: no pulse
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(2, 8'h90 + 8'(k), k == 3);
    wait_drain("exact");
    chk("exact_pulses", trunc_cnt, 0);
    chk("exact_len", txlog.size(), 5);

    // uart backpressure 1-0-0-1
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) push_byte(0, 8'h80 + 8'(k), k == 2);
    wait_drain("bp");
    ex(8'hA0); ex(8'h80); ex(8'h81); ex(8'h82);
    chk_seq("bp_tx", txlog);

    // requester stall mid-burst while others request
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(3, 8'hB0 + 8'(k), k == 3);
    wait_log("stall", 3);
    stall[3] = 1'b1;
    push_byte(0, 8'hC0, 1'b1);
    push_byte(1, 8'hC1, 1'b1);
    repeat (5) begin
      @(posedge clk); #2;
      chk("stall_grant", grant_id, 3);
      chk("stall_busy", busy, 1);
    end
    stall[3] = 1'b0;
    wait_drain("stall");
    ex(8'hA3); ex(8'hA0); ex(8'hA1);
    chk_seq("stall_hdr", hdrlog);

    // reset pulsed after the second data byte
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(2, 8'hD0 + 8'(k), k == 3);
    wait_log("rstmid", 3);
    reset = 1'b1;
    clear_stim();
    #1;
    chk("rstmid_tx_valid", tx_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_req_ready", req_ready, 0);
    chk("rstmid_tx_data", tx_data, 0);
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    clear_logs();
    push_byte(3, 8'hE3, 1'b1);
    push_byte(1, 8'hE1, 1'b1);
    wait_drain("rstmid");
    ex(8'hA1); ex(8'hE1); ex(8'hA3); ex(8'hE3);
    chk_seq("rstmid_tx", txlog);

    // randomized traffic with random stalls and backpressure
    do_reset();
    rdy_mode = 2;
    rand_stall = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) begin
        int r;
        int len;
        r = $urandom_range(0, NR - 1);
        len = $urandom_range(1, 6);
        if (rq[r].size() < 8)
          for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
      end
    end
    rand_stall = 1'b0;
    stall = '0;
    wait_drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the UART transmitter, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: byte width, matching the uart transmit path.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum data bytes per grant before forced release, at least 1.
REQ-004 SHALL have parameter HEADER_EN, default 1: when 1, a header byte precedes every burst.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: req_valid  in  NUM_REQ  per-requester byte valid.
REQ-008 SHALL have ports: req_data  in  NUM_REQ*DATA_WIDTH  flattened bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports: req_last  in  NUM_REQ  marks final byte of requester's message.
REQ-010 SHALL have ports: req_ready  out  NUM_REQ  per-requester byte accept.
REQ-011 SHALL have ports: tx_data  out  DATA_WIDTH; tx_valid  out  1; tx_ready  in  1  (to/from uart tx handshake).
REQ-012 SHALL have ports: grant_id  out  clog2(NUM_REQ)  current owner; busy  out  1  high outside IDLE; burst_trunc  out  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL transfer a byte on any interface only in a cycle where valid and ready are both high.
REQ-014 SHALL implement states IDLE, HEADER, DATA.
REQ-015 IDLE: tx_valid=0, req_ready=0; if any req_valid, SHALL latch grant_id = first asserted index searching upward from rr_ptr with wrap, then go to HEADER (HEADER_EN=1) or DATA (HEADER_EN=0) next cycle.
REQ-016 HEADER: tx_valid=1, tx_data = HEADER_BASE OR grant_id, all req_ready=0; on tx_ready SHALL go to DATA.
REQ-017 DATA: tx_valid = req_valid[grant_id], tx_data = req_data of grant_id, req_ready[grant_id] = tx_ready, all other req_ready=0; combinational pass-through, zero latency.
REQ-018 SHALL count data transfers in DATA in a counter of width clog2(MAX_BURST+1), cleared on entry to DATA.
REQ-019 SHALL leave DATA for IDLE after a transfer with req_last[grant_id]=1, or after the MAX_BURST-th transfer.
REQ-020 If the MAX_BURST-th transfer has req_last=0, SHALL pulse burst_trunc for the cycle after that transfer; if req_last=1 on that transfer, no pulse.
REQ-021 On leaving DATA SHALL set rr_ptr = grant_id+1, wrapping NUM_REQ-1 to 0.
REQ-022 Deassertion of req_valid[grant_id] in DATA SHALL NOT release the grant; scheduler waits, tx_valid low.
REQ-023 Requests from non-granted requesters SHALL be ignored until IDLE; minimum one IDLE cycle between bursts.
REQ-024 grant_id SHALL hold its value from grant until the next grant.

Reset
REQ-025 While reset is high, SHALL be in IDLE with rr_ptr=0, grant_id=0, count=0, tx_valid=0, tx_data=0, req_ready=0, busy=0, burst_trunc=0.
REQ-026 Reset asserted mid-burst SHALL abort immediately with no further transfers; first grant after release searches from index 0.

Structure
REQ-027 State enum, HEADER_BASE constant (8'hA0) and the clog2-derived width localparams SHALL live in shared package uart_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_pick (inputs request vector and pointer, outputs index and found flag), purely combinational.

Verification
REQ-029 Bench SHALL cover single request: req_valid[2] with bytes 0x11,0x22 (last on 0x22), HEADER_EN=1, tx_ready=1 -> tx sequence 0xA2,0x11,0x22, then IDLE, rr_ptr=3.
REQ-030 Bench SHALL cover round-robin: all four requesters continuously valid, 1-byte messages -> grants 0,1,2,3,0 in order.
REQ-031 Bench SHALL cover truncation: MAX_BURST=4, requester 1 sends 6 bytes without last -> 4 data bytes, burst_trunc pulses once, regrant later sends header 0xA1 and the remaining 2 bytes.
REQ-032 Bench SHALL cover backpressure: tx_ready toggling 1-0-0-1 during DATA -> tx_data stable while tx_valid && !tx_ready, no byte lost or duplicated.
REQ-033 Bench SHALL cover requester stall: req_valid[grant] low 5 cycles mid-burst while others request -> grant held, grant_id unchanged.
REQ-034 Bench SHALL cover reset mid-burst: reset pulsed after 2nd data byte -> all outputs at reset values same cycle; next grant goes to lowest requesting index.
